sc_epoch_sequencer: RTL and testbench
=====================================

// Module: sc_epoch_sequencer
// PURPOSE
//  Sequences one stochastic-computing evaluation epoch for the shared SN datapath.
//  Datapath = serial input capture, LFSR, SN generators, mul/add/self-mul, up-counters, serial output.
//  Frames each epoch as: input capture -> LFSR seed -> accumulation window -> result latch -> serial TX.
//  Replaces free-running epoch counting with an explicit start/busy/done handshake and a runtime window length.
// PARAMETERS
//  FRAME_BITS   10  serial frame length: 9 value bits + 1 buffer bit
//  CNT_W        18  width of cycle_cnt
//  WIN_LOG2_MIN 8   smallest allowed window exponent
//  WIN_LOG2_MAX 17  largest allowed window exponent (2^17 cycles)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset: synchronous, active-HIGH despite the name
//  start      in   1      request one epoch; sampled in IDLE only
//  abort      in   1      cancel the epoch in progress
//  continuous in   1      sampled at end of TX: 1 = chain straight into the next LOAD
//  win_log2   in   5      window exponent; sampled with start
//  cap_en     out  1      serial input shift enable (LOAD)
//  frame_sync out  1      first cycle of LOAD
//  seed_load  out  1      reload LFSR seed (SEED)
//  acc_clr    out  1      clear up-counters (SEED)
//  acc_en     out  1      up-counter count enable (RUN)
//  res_latch  out  1      copy up-counter result into average registers (LATCH)
//  tx_en      out  1      serial output shift enable (TX)
//  tx_sync    out  1      first cycle of TX
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse in the last TX cycle
//  state_o    out  3      current state encoding, for debug
//  cycle_cnt  out  CNT_W  cycles elapsed in the current state, counting from 0
// BEHAVIOUR
//  - Reset (rst_n=1 at posedge): state IDLE; all outputs 0; cycle_cnt 0; win register = WIN_LOG2_MIN.
//  - All outputs are registered Moore decodes of state/cycle_cnt. No combinational path from input to output.
//  - States: IDLE=0, LOAD=1, SEED=2, RUN=3, LATCH=4, TX=5. cycle_cnt clears to 0 on every state entry.
//  - IDLE: start=1 -> LOAD. win register <= clamp(win_log2, MIN, MAX).
//  - LOAD: cap_en=1 for FRAME_BITS cycles (cnt 0..9); frame_sync=1 at cnt 0. Then -> SEED.
//  - SEED: 1 cycle; seed_load=1 and acc_clr=1. Then -> RUN.
//  - RUN: acc_en=1 for exactly 2^win cycles (cnt 0..2^win-1). Then -> LATCH.
//  - LATCH: 1 cycle; res_latch=1. Then -> TX.
//  - TX: tx_en=1 for FRAME_BITS cycles; tx_sync=1 at cnt 0; done=1 at cnt 9.
//    After TX: continuous=1 -> LOAD, else -> IDLE.
//  - Latency: start sampled at edge k -> done high in cycle k+22+2^win.
//    Example: win=8 gives 278 cycles.
//  - start outside IDLE: ignored. win_log2 changes outside IDLE: ignored.
//  - abort=1 in any non-IDLE state: -> IDLE next cycle; all strobes 0; no res_latch, no done.
//  - abort=1 in IDLE: ignored. abort=1 with start=1 in IDLE: abort wins, stays IDLE.
//  - abort=1 in the last TX cycle: done still asserts that cycle; next state is IDLE even if continuous=1.
//  - rst_n mid-epoch: same as abort, plus win register is restored to its reset value.
//  - Clamp: win_log2 < 8 -> 8; win_log2 > 17 -> 17.
//    RUN count never wraps: terminal compare uses a CNT_W-wide 2^win-1.
//  - Exactly one of {cap_en, seed_load, acc_en, res_latch, tx_en} is high in any non-IDLE cycle.
//    acc_clr coincides with seed_load.
// STRUCTURE
//  - sc_ctrl_pkg holds: state enum (3-bit), FRAME_BITS, WIN_LOG2_MIN/MAX, and the clamp function.
//  - One sub-module: sc_window_counter.
//    Loadable CNT_W up-counter with clear-on-entry and terminal flag (cnt == limit).
//    Instantiated once and shared by all states; limit = 9 for LOAD/TX, 2^win-1 for RUN, 0 for SEED/LATCH.
//  - FSM and output decode stay in this module.
// TESTING
//  1. Reset, then start=1 for 1 cycle with win_log2=8, continuous=0.
//     -> cap_en 10 cycles, seed_load 1, acc_en 256, res_latch 1, tx_en 10.
//     -> done at start+278; busy low the next cycle.
//  2. win_log2=3, then win_log2=25.
//     -> acc_en high for 256 cycles and 131072 cycles respectively (clamp).
//  3. continuous=1, win_log2=8.
//     -> second frame_sync exactly 1 cycle after the first done; busy never drops; 3 epochs = 3 done pulses.
//  4. abort at RUN cnt 100.
//     -> IDLE next cycle; acc_en low; no res_latch or done.
//     -> new start then gives a clean full epoch.
//  5. start+abort in the same IDLE cycle -> stays IDLE.
//     start pulsed during RUN -> no effect on cycle count or done timing.
//  6. rst_n=1 for 1 cycle during TX cnt 4 -> all outputs 0 next cycle; cycle_cnt 0; state_o=0.

Source files
------------

// File: rtl/sc_ctrl_pkg.sv
// Shared types, constants and helpers for the stochastic-computing epoch sequencer.
package sc_ctrl_pkg;

    localparam int FRAME_BITS   = 10;
    localparam int CNT_W        = 18;
    localparam int WIN_W        = 5;
    localparam int WIN_LOG2_MIN = 8;
    localparam int WIN_LOG2_MAX = 17;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEED  = 3'd2,
        ST_RUN   = 3'd3,
        ST_LATCH = 3'd4,
        ST_TX    = 3'd5
    } state_t;

    function automatic logic [WIN_W-1:0] clamp_win(input logic [WIN_W-1:0] w);
        logic [WIN_W-1:0] r;
        if (w < WIN_W'(WIN_LOG2_MIN)) begin
            r = WIN_W'(WIN_LOG2_MIN);
        end else if (w > WIN_W'(WIN_LOG2_MAX)) begin
            r = WIN_W'(WIN_LOG2_MAX);
        end else begin
            r = w;
        end
        return r;
    endfunction

    // Full-width terminal value so the RUN compare never wraps at 2^17.
    function automatic logic [CNT_W-1:0] run_limit(input logic [WIN_W-1:0] w);
        return (CNT_W'(1) << w) - CNT_W'(1);
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Shared per-state cycle counter: clears on state entry, saturates, flags cnt == limit.
module sc_window_counter
    import sc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic             term
);

    // next count: zero on entry, hold at all-ones so a long IDLE cannot wrap
    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (cnt == {CNT_W{1'b1}}) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign term = (cnt == limit);

endmodule

// File: rtl/sc_epoch_sequencer.sv
// Epoch sequencer for the shared SN datapath: LOAD -> SEED -> RUN -> LATCH -> TX with start/busy/done.
module sc_epoch_sequencer
    import sc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic [4:0]       win_log2,
    output logic             cap_en,
    output logic             frame_sync,
    output logic             seed_load,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             res_latch,
    output logic             tx_en,
    output logic             tx_sync,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIN_W-1:0] win_r;
    logic [CNT_W-1:0] limit_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             term_s;
    logic             clr_s;

    logic cap_en_s, frame_sync_s, seed_load_s, acc_en_s;
    logic res_latch_s, tx_en_s, tx_sync_s, busy_s, done_s;

    // terminal count for the state currently being timed
    always_comb begin
        limit_s = '0;
        case (state_r)
            ST_LOAD: limit_s = CNT_W'(FRAME_BITS - 1);
            ST_TX:   limit_s = CNT_W'(FRAME_BITS - 1);
            ST_RUN:  limit_s = run_limit(win_r);
            default: limit_s = '0;
        endcase
    end

    assign clr_s = (state_next_s != state_r);

    sc_window_counter u_win_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_s),
        .limit    (limit_s),
        .cnt      (cycle_cnt),
        .cnt_next (cnt_next_s),
        .term     (term_s)
    );

    // next-state logic; abort outranks every other transition, including start in IDLE
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_next_s = ST_LOAD;
                    else       state_next_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (term_s) state_next_s = ST_SEED;
                    else        state_next_s = ST_LOAD;
                end
                ST_SEED: state_next_s = ST_RUN;
                ST_RUN: begin
                    if (term_s) state_next_s = ST_LATCH;
                    else        state_next_s = ST_RUN;
                end
                ST_LATCH: state_next_s = ST_TX;
                ST_TX: begin
                    if (!term_s)        state_next_s = ST_TX;
                    else if (continuous) state_next_s = ST_LOAD;
                    else                 state_next_s = ST_IDLE;
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // strobes decoded from the upcoming state so the registered outputs line up with state_o
    always_comb begin
        cap_en_s     = 1'b0;
        frame_sync_s = 1'b0;
        seed_load_s  = 1'b0;
        acc_en_s     = 1'b0;
        res_latch_s  = 1'b0;
        tx_en_s      = 1'b0;
        tx_sync_s    = 1'b0;
        done_s       = 1'b0;
        busy_s       = (state_next_s != ST_IDLE);
        case (state_next_s)
            ST_LOAD: begin
                cap_en_s     = 1'b1;
                frame_sync_s = (cnt_next_s == '0);
            end
            ST_SEED:  seed_load_s = 1'b1;
            ST_RUN:   acc_en_s    = 1'b1;
            ST_LATCH: res_latch_s = 1'b1;
            ST_TX: begin
                tx_en_s   = 1'b1;
                tx_sync_s = (cnt_next_s == '0);
                done_s    = (cnt_next_s == CNT_W'(FRAME_BITS - 1));
            end
            default: busy_s = 1'b0;
        endcase
    end

    // state, window exponent and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r    <= ST_IDLE;
            win_r      <= WIN_W'(WIN_LOG2_MIN);
            cap_en     <= 1'b0;
            frame_sync <= 1'b0;
            seed_load  <= 1'b0;
            acc_clr    <= 1'b0;
            acc_en     <= 1'b0;
            res_latch  <= 1'b0;
            tx_en      <= 1'b0;
            tx_sync    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_IDLE && state_next_s == ST_LOAD) begin
                win_r <= clamp_win(win_log2);
            end
            cap_en     <= cap_en_s;
            frame_sync <= frame_sync_s;
            seed_load  <= seed_load_s;
            acc_clr    <= seed_load_s;
            acc_en     <= acc_en_s;
            res_latch  <= res_latch_s;
            tx_en      <= tx_en_s;
            tx_sync    <= tx_sync_s;
            busy       <= busy_s;
            done       <= done_s;
        end
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_sc_epoch_sequencer.sv
// Self-checking bench: epoch-position reference model in lockstep, vector table and directed corner sequences.
module tb_sc_epoch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        continuous;
    logic [4:0]  win_log2;
    logic        cap_en, frame_sync, seed_load, acc_clr, acc_en;
    logic        res_latch, tx_en, tx_sync, busy, done;
    logic [2:0]  state_o;
    logic [17:0] cycle_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: an epoch is a position t in 0..21+n, n = 2^clamped window
    bit m_active;
    int m_t;
    int m_n;
    int m_idle;

    sc_epoch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .win_log2   (win_log2),
        .cap_en     (cap_en),
        .frame_sync (frame_sync),
        .seed_load  (seed_load),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .res_latch  (res_latch),
        .tx_en      (tx_en),
        .tx_sync    (tx_sync),
        .busy       (busy),
        .done       (done),
        .state_o    (state_o),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int ref_clamp(input logic [4:0] w);
        int v;
        v = int'(w);
        if (v < 8) return 8;
        if (v > 17) return 17;
        return v;
    endfunction

    task automatic model_step();
        if (rst_n) begin
            m_active = 1'b0;
            m_idle   = 0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1'b1;
                m_t      = 0;
                m_n      = 1 << ref_clamp(win_log2);
            end else if (m_idle < 262143) begin
                m_idle++;
            end
        end else if (abort) begin
            m_active = 1'b0;
            m_idle   = 0;
        end else if (m_t == 21 + m_n) begin
            if (continuous) m_t = 0;
            else begin
                m_active = 1'b0;
                m_idle   = 0;
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic compare_model();
        logic [9:0] eo;
        logic [9:0] ao;
        int es;
        int ec;
        // bit order: cap_en frame_sync seed_load acc_clr acc_en res_latch tx_en tx_sync busy done
        eo = 10'd0;
        if (!m_active) begin
            es = 0; ec = m_idle;
        end else if (m_t < 10) begin
            es = 1; ec = m_t;
            eo = {1'b1, (m_t == 0), 8'b0000_0010};
        end else if (m_t == 10) begin
            es = 2; ec = 0;
            eo = 10'b0011_0000_10;
        end else if (m_t < 11 + m_n) begin
            es = 3; ec = m_t - 11;
            eo = 10'b0000_1000_10;
        end else if (m_t == 11 + m_n) begin
            es = 4; ec = 0;
            eo = 10'b0000_0100_10;
        end else begin
            es = 5; ec = m_t - 12 - m_n;
            eo = {6'b0000_00, 1'b1, (ec == 0), 1'b1, (ec == 9)};
        end
        ao = {cap_en, frame_sync, seed_load, acc_clr, acc_en, res_latch, tx_en, tx_sync, busy, done};
        check("model_outputs", ao, eo);
        check("model_state", state_o, es);
        check("model_cycle_cnt", cycle_cnt, ec);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    // one non-continuous epoch; lat counts edges from the start edge to the cycle showing done
    task automatic run_epoch(input logic [4:0] w, input bit mid_start,
                             output int lat, output int acc, output int cap,
                             output int tx, output int latch, output int seed);
        acc = 0; cap = 0; tx = 0; latch = 0; seed = 0;
        win_log2 = w; continuous = 1'b0; start = 1'b1;
        tick();
        lat = 1;
        while (1'b1) begin
            acc += int'(acc_en); cap += int'(cap_en); tx += int'(tx_en);
            latch += int'(res_latch); seed += int'(seed_load);
            if (done || lat >= 5000) break;
            start = mid_start && state_o == 3'd3 && cycle_cnt == 18'd50;
            tick();
            lat++;
        end
        start = 1'b0;
        tick();
        check("busy_after_done", busy, 0);
    endtask

    typedef struct {
        logic [4:0] win;
        bit         mid_start;
        int         exp_acc;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, acc, cap, tx, latch, seed, n, dones, busy_drop, strobes;
        bit prev_done;

        vecs[0] = '{win: 5'd8,  mid_start: 1'b0, exp_acc: 256,  exp_lat: 278};
        vecs[1] = '{win: 5'd3,  mid_start: 1'b0, exp_acc: 256,  exp_lat: 278};
        vecs[2] = '{win: 5'd0,  mid_start: 1'b1, exp_acc: 256,  exp_lat: 278};
        vecs[3] = '{win: 5'd9,  mid_start: 1'b0, exp_acc: 512,  exp_lat: 534};
        vecs[4] = '{win: 5'd10, mid_start: 1'b1, exp_acc: 1024, exp_lat: 1046};
        vecs[5] = '{win: 5'd12, mid_start: 1'b0, exp_acc: 4096, exp_lat: 4118};

        rst_n = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; win_log2 = 5'd0;
        m_active = 1'b0; m_t = 0; m_n = 0; m_idle = 0;
        tick(); tick();
        check("reset_state", state_o, 0);
        check("reset_busy", busy, 0);
        check("reset_cnt", cycle_cnt, 0);
        rst_n = 1'b0;
        tick(); tick();

        // vector table: window length, clamp-low and mid-epoch start immunity
        foreach (vecs[i]) begin
            run_epoch(vecs[i].win, vecs[i].mid_start, lat, acc, cap, tx, latch, seed);
            check("epoch_latency", lat, vecs[i].exp_lat);
            check("acc_en_cycles", acc, vecs[i].exp_acc);
            check("cap_en_cycles", cap, 10);
            check("tx_en_cycles", tx, 10);
            check("res_latch_cycles", latch, 1);
            check("seed_load_cycles", seed, 1);
        end

        // clamp-high: 25 must behave as 17, still accumulating well past 2^8
        win_log2 = 5'd25; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (state_o != 3'd3 && n < 100) begin tick(); n++; end
        win_log2 = 5'd3;
        for (int i = 0; i < 2000; i++) tick();
        check("clamp_high_acc_en", acc_en, 1);
        check("clamp_high_cnt", cycle_cnt, 2000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);

        // continuous chaining: three back-to-back epochs
        win_log2 = 5'd8; continuous = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; dones = 0; busy_drop = 0; prev_done = 1'b0;
        while (dones < 3 && n < 2000) begin
            tick();
            n++;
            if (prev_done) check("frame_sync_after_done", frame_sync, 1);
            if (!busy) busy_drop++;
            if (done) begin
                dones++;
                if (dones == 3) continuous = 1'b0;
            end
            prev_done = done;
        end
        check("continuous_dones", dones, 3);
        check("continuous_busy_drop", busy_drop, 0);
        tick();
        check("continuous_end_busy", busy, 0);

        // abort at RUN cnt 100
        win_log2 = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(state_o == 3'd3 && cycle_cnt == 18'd100) && n < 600) begin tick(); n++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", state_o, 0);
        check("abort_acc_en", acc_en, 0);
        strobes = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            strobes += int'(res_latch) + int'(done);
        end
        check("abort_no_latch_done", strobes, 0);
        run_epoch(5'd8, 1'b0, lat, acc, cap, tx, latch, seed);
        check("epoch_after_abort", lat, 278);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 0);

        // abort in the final TX cycle overrides continuous
        continuous = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 400) begin tick(); n++; end
        check("last_tx_done_seen", done, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0; continuous = 1'b0;
        check("abort_last_tx_state", state_o, 0);

        // reset during TX cnt 4
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(state_o == 3'd5 && cycle_cnt == 18'd4) && n < 400) begin tick(); n++; end
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("rst_tx_outputs", {cap_en, frame_sync, seed_load, acc_clr, acc_en,
                                 res_latch, tx_en, tx_sync, busy, done}, 0);
        check("rst_tx_cnt", cycle_cnt, 0);
        check("rst_tx_state", state_o, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 15000; i++) begin
            rst_n      = ($urandom_range(0, 2999) == 0);
            start      = ($urandom_range(0, 3) == 0);
            abort      = ($urandom_range(0, 399) == 0);
            continuous = 1'($urandom_range(0, 1));
            win_log2   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31))
                                                     : 5'($urandom_range(0, 10));
            tick();
        end

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
